// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// busy-cycle counts and FSM state type.
package mdu_pkg;

  localparam int MDU_OP_W = 3;
  typedef logic [MDU_OP_W-1:0] mdu_op_t;

  localparam mdu_op_t MDU_MULT  = 3'b000;
  localparam mdu_op_t MDU_MULTU = 3'b001;
  localparam mdu_op_t MDU_DIV   = 3'b010;
  localparam mdu_op_t MDU_DIVU  = 3'b011;
  localparam mdu_op_t MDU_MTHI  = 3'b100;
  localparam mdu_op_t MDU_MTLO  = 3'b101;
  localparam mdu_op_t MDU_MADD  = 3'b110;
  localparam mdu_op_t MDU_MSUB  = 3'b111;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic {ST_IDLE, ST_BUSY} mdu_state_e;

  function automatic logic op_is_div(mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface mdu_if;
  logic                         start;
  logic [mdu_pkg::MDU_OP_W-1:0] MDUOp;
  logic [31:0]                  A;
  logic [31:0]                  B;
  logic                         busy;
  logic [31:0]                  HI;
  logic [31:0]                  LO;

  modport master (output start, MDUOp, A, B, input  busy, HI, LO);
  modport slave  (input  start, MDUOp, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu_calc.sv
// Combinational datapath: 64-bit {HI,LO} result for mult/div/accumulate ops
// and a divide-by-zero flag. Division shares one unsigned divider.
module mdu_calc
  import mdu_pkg::*;
(
  input  mdu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] acc,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic               is_signed_div;
  logic               a_neg;
  logic               b_neg;
  logic        [31:0] dividend;
  logic        [31:0] divisor;
  logic        [31:0] q_raw;
  logic        [31:0] r_raw;
  logic        [31:0] quot;
  logic        [31:0] rem;

  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'b0, a} * {32'b0, b};

  // Signed division runs on magnitudes; the result signs are restored after,
  // which also yields 0x80000000 for 0x80000000 / -1 without overflow.
  assign is_signed_div = (op == MDU_DIV);
  assign a_neg         = is_signed_div & a[31];
  assign b_neg         = is_signed_div & b[31];
  assign dividend      = a_neg ? -a : a;
  assign divisor       = (b == 32'd0) ? 32'd1 : (b_neg ? -b : b);
  assign q_raw         = dividend / divisor;
  assign r_raw         = dividend % divisor;
  assign quot          = (a_neg ^ b_neg) ? -q_raw : q_raw;
  assign rem           = a_neg ? -r_raw : r_raw;

  assign div_by_zero   = op_is_div(op) && (b == 32'd0);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    result = 64'd0;
    unique case (op)
      MDU_MULT:          result = sprod;
      MDU_MULTU:         result = uprod;
      MDU_DIV, MDU_DIVU: result = {rem, quot};
      MDU_MADD:          result = acc + sprod;
      MDU_MSUB:          result = acc - sprod;
      default:           result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional madd/msub support is enabled by defining MDU_MADD_EN.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam logic [4:0] MULT_CNT = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_CNT  = 5'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        launch;
  logic [4:0]  launch_cnt;
  logic [63:0] calc_result;
  logic        calc_div_by_zero;

  mdu_calc u_calc (
    .op          (bus.MDUOp),
    .a           (bus.A),
    .b           (bus.B),
    .acc         ({hi_q, lo_q}),
    .result      (calc_result),
    .div_by_zero (calc_div_by_zero)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      pend_hi_q  <= 32'd0;
      pend_lo_q  <= 32'd0;
      pend_vld_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_vld_q <= pend_vld_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    pend_vld_d = pend_vld_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    launch     = 1'b0;
    launch_cnt = MULT_CNT;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          unique case (bus.MDUOp)
            MDU_MULT, MDU_MULTU: launch = 1'b1;
            MDU_DIV, MDU_DIVU: begin
              launch     = 1'b1;
              launch_cnt = DIV_CNT;
            end
            MDU_MTHI: hi_d = bus.A;
            MDU_MTLO: lo_d = bus.A;
            MDU_MADD, MDU_MSUB: begin
`ifdef MDU_MADD_EN
              launch = 1'b1;
`endif
            end
            default: ;
          endcase
        end
        if (launch) begin
          pend_hi_d  = calc_result[63:32];
          pend_lo_d  = calc_result[31:0];
          pend_vld_d = !calc_div_by_zero;
          cnt_d      = launch_cnt;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Requests arriving while busy are dropped; the stall logic holds them.
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = ST_IDLE;
          if (pend_vld_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == ST_BUSY);
    bus.HI   = hi_q;
    bus.LO   = lo_q;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits in the execute stage beside the ALU and consumes the same GRF operands (RD1 as A, RD2 as B). Its busy output lets the hazard logic stall dependent HI/LO instructions, and its HI/LO outputs feed the register-write data mux for mfhi/mflo.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/msub); legal range 1–31
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1–31
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk
- start  in  1  request strobe; MDUOp, A and B are valid in the same cycle
- MDUOp  in  3  operation code:
  - 000 mult, 001 multu, 010 div, 011 divu
  - 100 mthi, 101 mtlo
  - 110 madd, 111 msub (only with the macro)
- A  in  32  operand rs
- B  in  32  operand rt
- busy  out  1  operation in flight; registered
- HI  out  32  architectural HI; registered
- LO  out  32  architectural LO; registered

## Operation
- States:
  - IDLE: busy=0
  - BUSY: busy=1; 5-bit down-counter cnt
- IDLE with start=1 and a mult/div-class op:
  - capture the computed 64-bit result into pending registers pend_hi and pend_lo
  - load cnt with MULT_CYCLES or DIV_CYCLES, then go to BUSY
- IDLE with start=1 and mthi/mtlo: HI (resp. LO) ← A at that edge; no BUSY entry.
- BUSY: cnt decrements each edge. On the edge where cnt==1, HI←pend_hi, LO←pend_lo, and the state returns to IDLE.
- start while busy=1 is ignored, including mthi/mtlo. Upstream stalls; the unit does not queue.
- Arithmetic:
  - mult: signed 32×32→64, {HI,LO}=product
  - multu: unsigned 32×32→64, {HI,LO}=product
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of A
  - divu: unsigned quotient and remainder
  - 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0
- Divide by zero (B==0): full DIV_CYCLES busy period; HI/LO keep their prior values, with no commit.
- HI/LO are unchanged throughout BUSY until the commit edge. Reads during busy return old values; hazard logic must stall mfhi/mflo on busy.
- Reset (reset=0 at an edge), including mid-operation: state=IDLE, cnt=0, busy=0, HI=0, LO=0, pending result discarded.

## Timing
- Start accepted at edge E0. busy=1 from just after E0 through just after E(N-1); commit and busy=0 at edge EN, where N=MULT_CYCLES or DIV_CYCLES.
- busy is 0 in the cycle start is presented. The stall unit ORs start with busy.
- mthi/mtlo: HI/LO visible the cycle after the start edge; latency 1.
- A start in the first IDLE cycle after a commit is accepted. Back-to-back ops have zero bubble beyond the busy window.
- reset=0 overrides start in the same cycle.

## Configuration
- MDU_MADD_EN defined:
  - 110 madd: {HI,LO} ← {HI,LO} + signed(A)×signed(B), modulo 2^64
  - 111 msub: {HI,LO} ← {HI,LO} − signed(A)×signed(B), modulo 2^64
  - both use MULT_CYCLES
  - the accumulate operand is {HI,LO} sampled at the start edge
- MDU_MADD_EN undefined: codes 110/111 are treated as no-ops. Nothing is started, busy stays 0, and HI/LO are unchanged.

## Structure
- Shared package mdu_pkg:
  - MDUOp encodings as named localparams (MDU_MULT … MDU_MSUB)
  - default cycle constants
  - 3-bit op width constant
- Sub-module mdu_calc (combinational):
  - inputs MDUOp, A, B, {HI,LO}
  - outputs the 64-bit result and a div_by_zero flag
- Top level holds the state machine, counter, pending registers and HI/LO.

## Test plan
- multu, A=0xFFFFFFFF, B=0x2 → busy high for exactly 5 cycles, then HI=0x00000001, LO=0xFFFFFFFE.
- div, A=-7 (0xFFFFFFF9), B=2 → after 10 busy cycles: LO=0xFFFFFFFD, HI=0xFFFFFFFF. HI/LO hold their old values every cycle before the commit.
- divu, B=0, with prior HI=0x11, LO=0x22 → busy for 10 cycles; HI=0x11, LO=0x22 afterwards.
- mult 3×4 started, then mtlo A=0x55 presented while busy → mtlo ignored; final LO=0x0000000C, HI=0.
- div started, reset low at busy cycle 4 → next cycle busy=0, HI=LO=0; a fresh mult 2×3 then yields LO=6.
- With MDU_MADD_EN, HI=0, LO=10: madd 2×3 → LO=16. Without the macro, the same op → busy stays 0 and LO stays 10.
